// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use bubbles, branch squash and the
// multdiv hold, driving PC / F/D / D/X / X/M enables and flushes.
module hazard_ctrl (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] fd_insn,
    input  logic [31:0] dx_insn,
    input  logic        branch_taken,
    input  logic        md_ready,
    output logic        pc_en,
    output logic        fd_en,
    output logic        dx_en,
    output logic        fd_flush,
    output logic        dx_flush,
    output logic        xm_nop,
    output logic        md_start,
    output logic [15:0] stall_count
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state;

    logic [4:0] fd_op, fd_rd, fd_rs, fd_rt;
    logic [4:0] dx_op, dx_rd, dx_alu;
    logic       dx_lw, dx_md, load_use;

    assign fd_op  = fd_insn[31:27];
    assign fd_rd  = fd_insn[26:22];
    assign fd_rs  = fd_insn[21:17];
    assign fd_rt  = fd_insn[16:12];
    assign dx_op  = dx_insn[31:27];
    assign dx_rd  = dx_insn[26:22];
    assign dx_alu = dx_insn[6:2];

    assign dx_lw = (dx_op == 5'b01000);
    assign dx_md = (dx_op == 5'b00000) && ((dx_alu == 5'b00110) || (dx_alu == 5'b00111));

    assign load_use = dx_lw && (dx_rd != 5'd0) &&
                      ((fd_rs == dx_rd) ||
                       ((fd_op == 5'b00000) && (fd_rt == dx_rd)) ||
                       ((fd_op == 5'b00111) && (fd_rd == dx_rd)));

    always_comb begin
        pc_en    = 1'b1;
        fd_en    = 1'b1;
        dx_en    = 1'b1;
        fd_flush = 1'b0;
        dx_flush = 1'b0;
        xm_nop   = 1'b0;
        md_start = 1'b0;
        // Stall cycles freeze the front end and feed bubbles into X/M;
        // a branch cannot be resolving while the multdiv owns X.
        if (!reset && ((state == IDLE && dx_md) || state == BUSY)) begin
            pc_en    = 1'b0;
            fd_en    = 1'b0;
            dx_en    = 1'b0;
            xm_nop   = 1'b1;
            md_start = (state == IDLE);
        end else if (!reset) begin
            if (branch_taken) begin
                fd_flush = 1'b1;
                dx_flush = 1'b1;
            end else if (load_use) begin
                pc_en    = 1'b0;
                fd_en    = 1'b0;
                dx_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            stall_count <= 16'd0;
        end else begin
            case (state)
                IDLE:    if (dx_md) state <= BUSY;
                BUSY:    if (md_ready) state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
            if (!pc_en && stall_count != 16'hFFFF)
                stall_count <= stall_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboarded bench for hazard_ctrl: per-cycle expected output vectors are
// queued as stimulus is applied and checked at the following falling edge.
module tb_hazard_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] fd_insn = '0, dx_insn = '0;
    logic        branch_taken = 1'b0, md_ready = 1'b0;
    logic        pc_en, fd_en, dx_en, fd_flush, dx_flush, xm_nop, md_start;
    logic [15:0] stall_count;

    hazard_ctrl dut (
        .clock(clock), .reset(reset), .fd_insn(fd_insn), .dx_insn(dx_insn),
        .branch_taken(branch_taken), .md_ready(md_ready),
        .pc_en(pc_en), .fd_en(fd_en), .dx_en(dx_en), .fd_flush(fd_flush),
        .dx_flush(dx_flush), .xm_nop(xm_nop), .md_start(md_start),
        .stall_count(stall_count)
    );

    always #5 clock = ~clock;

    // {pc_en, fd_en, dx_en, fd_flush, dx_flush, xm_nop, md_start}
    localparam logic [6:0] NORM  = 7'b111_000_0;
    localparam logic [6:0] STALL = 7'b000_001_0;
    localparam logic [6:0] START = 7'b000_001_1;
    localparam logic [6:0] BR    = 7'b111_110_0;
    localparam logic [6:0] LU    = 7'b001_010_0;

    localparam logic [31:0] NOP      = 32'd0;
    localparam logic [31:0] MUL      = {5'b00000, 5'd3, 5'd1, 5'd2, 5'd0, 5'b00110, 2'b00};
    localparam logic [31:0] DIV      = {5'b00000, 5'd4, 5'd1, 5'd2, 5'd0, 5'b00111, 2'b00};
    localparam logic [31:0] LW5      = {5'b01000, 5'd5, 5'd1, 5'd0, 5'd0, 5'd0, 2'b00};
    localparam logic [31:0] LW0      = {5'b01000, 5'd0, 5'd1, 5'd0, 5'd0, 5'd0, 2'b00};
    localparam logic [31:0] ADD_RS5  = {5'b00000, 5'd6, 5'd5, 5'd2, 5'd0, 5'd0, 2'b00};
    localparam logic [31:0] ADD_RT5  = {5'b00000, 5'd6, 5'd2, 5'd5, 5'd0, 5'd0, 2'b00};
    localparam logic [31:0] ADD_R0   = {5'b00000, 5'd6, 5'd0, 5'd2, 5'd0, 5'd0, 2'b00};
    localparam logic [31:0] SW5      = {5'b00111, 5'd5, 5'd2, 5'd0, 5'd0, 5'd0, 2'b00};
    localparam logic [31:0] ADDI_RT5 = {5'b00101, 5'd6, 5'd2, 5'd5, 5'd0, 5'd0, 2'b00};

    typedef struct {
        logic [31:0] fd, dx;
        logic        br, rdy, rst;
        logic [6:0]  exp;
    } vec_t;

    logic [6:0]  exp_q[$];
    logic [15:0] cnt_q[$];
    int          vecs = 0, miss = 0;
    logic [15:0] cnt = '0;

    function automatic logic [6:0] outs();
        return {pc_en, fd_en, dx_en, fd_flush, dx_flush, xm_nop, md_start};
    endfunction

    function automatic vec_t mk(logic [31:0] fd, logic [31:0] dx, logic br,
                                logic rdy, logic rst, logic [6:0] exp);
        vec_t v;
        v.fd = fd; v.dx = dx; v.br = br; v.rdy = rdy; v.rst = rst; v.exp = exp;
        return v;
    endfunction

    // Drive one cycle of stimulus and queue the outputs it must produce.
    task automatic apply(input vec_t v);
        fd_insn = v.fd; dx_insn = v.dx; branch_taken = v.br;
        md_ready = v.rdy; reset = v.rst;
        exp_q.push_back(v.exp);
    endtask

    // Reference stall counter, advanced from the expected pc_en of each cycle.
    task automatic model_edge(input logic rst, input logic [6:0] e);
        if (rst) cnt = '0;
        else if (!e[6] && cnt != 16'hFFFF) cnt = cnt + 16'd1;
        cnt_q.push_back(cnt);
    endtask

    task automatic test_reset();
        vec_t v[$];
        logic [6:0] e; logic [15:0] c;
        v.push_back(mk(NOP, MUL, 0, 0, 1, NORM));
        v.push_back(mk(NOP, MUL, 0, 0, 1, NORM));
        v.push_back(mk(NOP, MUL, 0, 1, 0, START));
        v.push_back(mk(NOP, MUL, 0, 0, 0, STALL));
        v.push_back(mk(NOP, MUL, 0, 1, 0, STALL));
        v.push_back(mk(NOP, MUL, 0, 0, 0, NORM));
        v.push_back(mk(NOP, NOP, 0, 0, 0, NORM));
        foreach (v[i]) begin
            apply(v[i]);
            @(negedge clock);
            e = exp_q.pop_front(); vecs++;
            if (outs() !== e) begin miss++; $display("FAIL reset[%0d] outs=%b want %b", i, outs(), e); end
            @(posedge clock); #1;
            model_edge(v[i].rst, e); c = cnt_q.pop_front(); vecs++;
            if (stall_count !== c) begin miss++; $display("FAIL reset_cnt[%0d] got %0d want %0d", i, stall_count, c); end
        end
    endtask

    task automatic test_load_use();
        vec_t v[$];
        logic [6:0] e; logic [15:0] c;
        v.push_back(mk(NOP, NOP, 0, 0, 1, NORM));
        v.push_back(mk(ADD_RS5, LW5, 0, 0, 0, LU));
        v.push_back(mk(ADD_RS5, NOP, 0, 0, 0, NORM));
        v.push_back(mk(ADD_R0, LW0, 0, 0, 0, NORM));
        v.push_back(mk(ADD_RT5, LW5, 0, 0, 0, LU));
        v.push_back(mk(SW5, LW5, 0, 0, 0, LU));
        v.push_back(mk(ADDI_RT5, LW5, 0, 0, 0, NORM));
        v.push_back(mk(ADD_RS5, MUL, 0, 0, 0, START));
        v.push_back(mk(ADD_RS5, MUL, 0, 1, 0, STALL));
        v.push_back(mk(ADD_RS5, MUL, 0, 0, 0, NORM));
        foreach (v[i]) begin
            apply(v[i]);
            @(negedge clock);
            e = exp_q.pop_front(); vecs++;
            if (outs() !== e) begin miss++; $display("FAIL load_use[%0d] outs=%b want %b", i, outs(), e); end
            @(posedge clock); #1;
            model_edge(v[i].rst, e); c = cnt_q.pop_front(); vecs++;
            if (stall_count !== c) begin miss++; $display("FAIL load_use_cnt[%0d] got %0d want %0d", i, stall_count, c); end
        end
    endtask

    task automatic test_branch();
        vec_t v[$];
        logic [6:0] e; logic [15:0] c;
        v.push_back(mk(NOP, NOP, 0, 0, 1, NORM));
        v.push_back(mk(ADD_RS5, LW5, 1, 0, 0, BR));
        v.push_back(mk(NOP, NOP, 1, 0, 0, BR));
        v.push_back(mk(NOP, MUL, 1, 0, 0, START));
        v.push_back(mk(NOP, MUL, 1, 1, 0, STALL));
        v.push_back(mk(NOP, MUL, 1, 0, 0, BR));
        v.push_back(mk(NOP, NOP, 0, 0, 0, NORM));
        foreach (v[i]) begin
            apply(v[i]);
            @(negedge clock);
            e = exp_q.pop_front(); vecs++;
            if (outs() !== e) begin miss++; $display("FAIL branch[%0d] outs=%b want %b", i, outs(), e); end
            @(posedge clock); #1;
            model_edge(v[i].rst, e); c = cnt_q.pop_front(); vecs++;
            if (stall_count !== c) begin miss++; $display("FAIL branch_cnt[%0d] got %0d want %0d", i, stall_count, c); end
        end
    endtask

    task automatic test_back_to_back();
        vec_t v[$];
        logic [6:0] e; logic [15:0] c;
        v.push_back(mk(NOP, NOP, 0, 0, 1, NORM));
        v.push_back(mk(NOP, MUL, 0, 0, 0, START));
        v.push_back(mk(NOP, MUL, 0, 0, 0, STALL));
        v.push_back(mk(NOP, MUL, 0, 0, 0, STALL));
        v.push_back(mk(NOP, MUL, 0, 1, 0, STALL));
        v.push_back(mk(NOP, MUL, 0, 0, 0, NORM));
        v.push_back(mk(NOP, DIV, 0, 0, 0, START));
        v.push_back(mk(NOP, DIV, 0, 1, 0, STALL));
        v.push_back(mk(NOP, DIV, 0, 0, 0, NORM));
        v.push_back(mk(NOP, NOP, 0, 0, 0, NORM));
        foreach (v[i]) begin
            apply(v[i]);
            @(negedge clock);
            e = exp_q.pop_front(); vecs++;
            if (outs() !== e) begin miss++; $display("FAIL multdiv[%0d] outs=%b want %b", i, outs(), e); end
            @(posedge clock); #1;
            model_edge(v[i].rst, e); c = cnt_q.pop_front(); vecs++;
            if (stall_count !== c) begin miss++; $display("FAIL multdiv_cnt[%0d] got %0d want %0d", i, stall_count, c); end
        end
    endtask

    task automatic test_reset_busy();
        vec_t v[$];
        logic [6:0] e; logic [15:0] c;
        v.push_back(mk(NOP, NOP, 0, 0, 1, NORM));
        v.push_back(mk(NOP, MUL, 0, 0, 0, START));
        v.push_back(mk(NOP, MUL, 0, 0, 0, STALL));
        v.push_back(mk(NOP, MUL, 0, 0, 1, NORM));
        v.push_back(mk(NOP, NOP, 0, 1, 0, NORM));
        v.push_back(mk(NOP, NOP, 0, 0, 0, NORM));
        v.push_back(mk(NOP, MUL, 0, 0, 0, START));
        v.push_back(mk(NOP, MUL, 0, 1, 0, STALL));
        v.push_back(mk(NOP, MUL, 0, 0, 0, NORM));
        foreach (v[i]) begin
            apply(v[i]);
            @(negedge clock);
            e = exp_q.pop_front(); vecs++;
            if (outs() !== e) begin miss++; $display("FAIL reset_busy[%0d] outs=%b want %b", i, outs(), e); end
            @(posedge clock); #1;
            model_edge(v[i].rst, e); c = cnt_q.pop_front(); vecs++;
            if (stall_count !== c) begin miss++; $display("FAIL reset_busy_cnt[%0d] got %0d want %0d", i, stall_count, c); end
        end
    endtask

    task automatic test_saturation();
        logic [6:0] e; logic [15:0] c;
        apply(mk(NOP, NOP, 0, 0, 1, NORM));
        @(negedge clock); void'(exp_q.pop_front());
        @(posedge clock); #1;
        cnt = '0;
        apply(mk(NOP, MUL, 0, 0, 0, STALL));
        void'(exp_q.pop_front());
        // After i edges there have been i stall cycles (start + i-1 BUSY).
        for (int i = 1; i <= 70000; i++) begin
            @(posedge clock); #1;
            if (i == 65534 || i == 65535 || i == 65536 || i == 70000) begin
                cnt_q.push_back((i >= 65535) ? 16'hFFFF : 16'(i));
                c = cnt_q.pop_front(); vecs++;
                if (stall_count !== c) begin miss++; $display("FAIL sat_cnt[%0d] got %h want %h", i, stall_count, c); end
            end
        end
        apply(mk(NOP, MUL, 0, 1, 0, STALL));
        @(negedge clock);
        e = exp_q.pop_front(); vecs++;
        if (outs() !== e) begin miss++; $display("FAIL sat_busy outs=%b want %b", outs(), e); end
        @(posedge clock); #1;
        apply(mk(NOP, MUL, 0, 0, 0, NORM));
        @(negedge clock);
        e = exp_q.pop_front(); vecs++;
        if (outs() !== e) begin miss++; $display("FAIL sat_done outs=%b want %b", outs(), e); end
        @(posedge clock); #1;
        cnt_q.push_back(16'hFFFF);
        c = cnt_q.pop_front(); vecs++;
        if (stall_count !== c) begin miss++; $display("FAIL sat_hold got %h want %h", stall_count, c); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_back_to_back();
        test_reset_busy();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
